oled_frame_streamer: RTL and testbench

//  Reads the OLED frame buffer (block RAM, 1-cycle registered read) page by page and streams it as a

---
 rtl/oled_frame_streamer_pkg.sv | 25 ++
 rtl/oled_frame_streamer_if.sv | 14 +
 rtl/oled_frame_streamer.sv | 170 +++++++++++++++++
 tb/tb_oled_frame_streamer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_frame_streamer_pkg.sv
// Shared definitions for the OLED frame streamer: SSD1306-style command
// bytes, the FSM state encoding and a helper that builds the page command.
package oled_frame_streamer_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t CMD_PAGE_BASE = 8'hB0;
    localparam byte_t CMD_COL_LO    = 8'h00;
    localparam byte_t CMD_COL_HI    = 8'h10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_OUT  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Page-address command: the base opcode with the page number in the low bits.
    function automatic byte_t page_cmd(input byte_t page);
        return CMD_PAGE_BASE | page;
    endfunction

endpackage

// File: rtl/oled_frame_streamer_if.sv
// Byte stream from the frame streamer to the SPI byte sender.
// A byte moves when out_valid and out_ready are both high at a rising edge.
interface oled_frame_streamer_if;
    import oled_frame_streamer_pkg::*;

    logic  out_valid;
    logic  out_ready;
    byte_t out_data;
    logic  out_dc;

    modport master (output out_valid, output out_data, output out_dc, input out_ready);
    modport slave  (input out_valid, input out_data, input out_dc, output out_ready);

endinterface

// File: rtl/oled_frame_streamer.sv
// Walks the frame buffer page by page. Each page starts with three command
// bytes (page address, column low, column high), followed by one data byte
// per column read from the block RAM. All outputs are registered; read_addr
// comes straight from the registered page/column counters.
module oled_frame_streamer
    import oled_frame_streamer_pkg::*;
#(
    parameter int COLUMNS    = 128,
    parameter int PAGES      = 4,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  byte_t                 read_data,
    oled_frame_streamer_if.master out_if
);

    localparam int COL_W = $clog2(COLUMNS);
    localparam int PAGE_W = $clog2(PAGES);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLUMNS - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

    state_t              state, state_n;
    logic [PAGE_W-1:0]   page, page_n;
    logic [COL_W-1:0]    col, col_n;
    logic [1:0]          cmd_idx, cmd_idx_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;
    logic                valid_q, valid_n;
    byte_t               data_q, data_n;
    logic                dc_q, dc_n;

    logic                handshake;
    logic                col_last;
    logic                page_last;

    assign handshake = valid_q && out_if.out_ready;
    assign col_last  = (col == COL_LAST);
    assign page_last = (page == PAGE_LAST);

    assign read_addr        = ADDR_WIDTH'({page, col});
    assign busy             = busy_q;
    assign done             = done_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_dc    = dc_q;

    // State register plus the registered outputs and counters it owns.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            page    <= '0;
            col     <= '0;
            cmd_idx <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            dc_q    <= 1'b0;
        end else begin
            state   <= state_n;
            page    <= page_n;
            col     <= col_n;
            cmd_idx <= cmd_idx_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            valid_q <= valid_n;
            data_q  <= data_n;
            dc_q    <= dc_n;
        end
    end

    // Next-state selection; start is only looked at in IDLE so a pulse while busy is dropped.
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (start) state_n = ST_CMD;
            ST_CMD:  if (handshake && cmd_idx == 2'd2) state_n = ST_RD;
            ST_RD:   state_n = ST_WAIT;
            ST_WAIT: state_n = ST_OUT;
            ST_OUT: begin
                if (handshake) begin
                    if (!col_last)       state_n = ST_RD;
                    else if (!page_last) state_n = ST_CMD;
                    else                 state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Next values of outputs and counters; a byte is loaded together with the move into the state that presents it.
    always_comb begin
        page_n    = page;
        col_n     = col;
        cmd_idx_n = cmd_idx;
        busy_n    = busy_q;
        done_n    = 1'b0;
        valid_n   = valid_q;
        data_n    = data_q;
        dc_n      = dc_q;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    busy_n    = 1'b1;
                    cmd_idx_n = 2'd0;
                    col_n     = '0;
                    valid_n   = 1'b1;
                    dc_n      = 1'b0;
                    data_n    = page_cmd(8'(page));
                end
            end
            ST_CMD: begin
                if (handshake) begin
                    unique case (cmd_idx)
                        2'd0: begin
                            cmd_idx_n = 2'd1;
                            data_n    = CMD_COL_LO;
                        end
                        2'd1: begin
                            cmd_idx_n = 2'd2;
                            data_n    = CMD_COL_HI;
                        end
                        default: begin
                            cmd_idx_n = 2'd0;
                            valid_n   = 1'b0;
                        end
                    endcase
                end
            end
            ST_RD: begin
            end
            ST_WAIT: begin
                valid_n = 1'b1;
                dc_n    = 1'b1;
                data_n  = read_data;
            end
            ST_OUT: begin
                if (handshake) begin
                    valid_n = 1'b0;
                    if (!col_last) begin
                        col_n = col + COL_W'(1);
                    end else if (!page_last) begin
                        col_n     = '0;
                        page_n    = page + PAGE_W'(1);
                        cmd_idx_n = 2'd0;
                        valid_n   = 1'b1;
                        dc_n      = 1'b0;
                        data_n    = page_cmd(8'(page) + 8'd1);
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                busy_n = 1'b0;
                page_n = '0;
                col_n  = '0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Directed bench for oled_frame_streamer: reset, full frame, backpressure,
// ignored restart, mid-frame reset and handshake latency.
module tb_oled_frame_streamer;
    import oled_frame_streamer_pkg::*;

    localparam int FRAME_BYTES = 524;
    localparam int PAGE_BYTES  = 131;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       busy;
    logic       done;
    logic [8:0] read_addr;
    byte_t      read_data;
    byte_t      mem [512];

    oled_frame_streamer_if sif ();

    oled_frame_streamer #(.COLUMNS(128), .PAGES(4), .ADDR_WIDTH(9)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .read_addr (read_addr),
        .read_data (read_data),
        .out_if    (sif)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;
    logic [8:0] byte_q [$];
    int hs_q [$];
    int done_count = 0;
    int done_cyc = 0;
    int stable_errs = 0;
    int stall_count = 0;
    logic was_stalled = 1'b0;
    byte_t held_data;
    logic held_dc;

    // Clock generation.
    always #5 clk = ~clk;

    // Block RAM model with one-cycle registered read.
    always @(posedge clk) read_data <= mem[read_addr];

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Ready driver: held low, held high, or random with about 30% stall cycles.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 2) sif.out_ready = ($urandom_range(0, 9) >= 3);
        else sif.out_ready = (ready_mode == 1);
    end

    // Stream monitor: records accepted bytes, done pulses and stall stability.
    always @(negedge clk) begin
        if (was_stalled) begin
            if (!sif.out_valid || sif.out_data != held_data || sif.out_dc != held_dc)
                stable_errs++;
        end
        was_stalled = sif.out_valid && !sif.out_ready;
        held_data = sif.out_data;
        held_dc = sif.out_dc;
        if (sif.out_valid && !sif.out_ready) stall_count++;
        if (sif.out_valid && sif.out_ready) begin
            byte_q.push_back({sif.out_dc, sif.out_data});
            hs_q.push_back(cyc);
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    task automatic check_output(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives start/rstn for one clock edge and returns #1 after it with start back low.
    task automatic apply_stimulus(input logic start_v, input logic rstn_v);
        start = start_v;
        rstn = rstn_v;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_monitor();
        byte_q.delete();
        hs_q.delete();
        done_count = 0;
        stable_errs = 0;
        stall_count = 0;
        was_stalled = 1'b0;
    endtask

    function automatic logic [8:0] expected_byte(input int i);
        int pg;
        int off;
        pg = i / PAGE_BYTES;
        off = i % PAGE_BYTES;
        if (off == 0) return {1'b0, 8'hB0 | 8'(pg)};
        if (off == 1) return 9'h000;
        if (off == 2) return 9'h010;
        return {1'b1, 8'((pg * 128 + off - 3) & 255)};
    endfunction

    task automatic wait_frame(input string tag, input int budget);
        int n;
        n = 0;
        while (done_count == 0 && n < budget) begin
            step(1);
            n++;
        end
        check_output({tag, "_done_in_time"}, int'(n < budget), 1);
    endtask

    task automatic check_stream(input string tag);
        int first_bad;
        first_bad = -1;
        for (int i = 0; i < byte_q.size(); i++) begin
            if (first_bad < 0 && byte_q[i] != expected_byte(i)) first_bad = i;
        end
        check_output({tag, "_byte_count"}, byte_q.size(), FRAME_BYTES);
        check_output({tag, "_first_bad_index"}, first_bad, -1);
    endtask

    initial begin
        int bad_gap;
        int n;
        for (int a = 0; a < 512; a++) mem[a] = byte_t'(a & 255);
        sif.out_ready = 1'b0;

        // Reset held two cycles with start asserted.
        start = 1'b1;
        rstn = 1'b0;
        step(2);
        check_output("rst_busy", busy, 0);
        check_output("rst_valid", sif.out_valid, 0);
        check_output("rst_done", done, 0);
        check_output("rst_read_addr", read_addr, 0);
        check_output("rst_out_data", sif.out_data, 0);
        check_output("rst_out_dc", sif.out_dc, 0);
        apply_stimulus(1'b0, 1'b1);

        // Full frame with ready held high, plus latency checks.
        ready_mode = 1;
        step(2);
        clear_monitor();
        apply_stimulus(1'b1, 1'b1);
        check_output("lat_first_valid", sif.out_valid, 1);
        check_output("lat_first_data", sif.out_data, 8'hB0);
        check_output("lat_first_dc", sif.out_dc, 0);
        check_output("lat_busy", busy, 1);
        wait_frame("s2", 3000);
        check_output("s2_busy_after", busy, 0);
        check_output("s2_done_one_cycle", done, 0);
        check_stream("s2");
        check_output("s2_p2_cmd_page", byte_q[262], 9'h0B2);
        check_output("s2_p2_cmd_lo", byte_q[263], 9'h000);
        check_output("s2_p2_cmd_hi", byte_q[264], 9'h010);
        check_output("s2_p2_first_data", byte_q[265], 9'h100);
        check_output("s2_p2_last_data", byte_q[392], 9'h17F);
        check_output("s2_done_count", done_count, 1);
        check_output("s2_done_after_last", done_cyc, hs_q[hs_q.size() - 1] + 1);
        bad_gap = 0;
        for (int i = 1; i < hs_q.size(); i++) begin
            if ((i % PAGE_BYTES) > 3 && hs_q[i] - hs_q[i - 1] != 3) bad_gap++;
        end
        check_output("lat_data_gap_3", bad_gap, 0);

        // Random backpressure: same byte stream, stable while stalled.
        ready_mode = 2;
        step(3);
        clear_monitor();
        apply_stimulus(1'b1, 1'b1);
        wait_frame("s3", 8000);
        step(2);
        check_stream("s3");
        check_output("s3_stable_when_stalled", stable_errs, 0);
        check_output("s3_stalls_seen", int'(stall_count > 0), 1);
        check_output("s3_done_count", done_count, 1);

        // Restart pulse mid-frame is ignored.
        ready_mode = 1;
        step(3);
        clear_monitor();
        apply_stimulus(1'b1, 1'b1);
        step(300);
        apply_stimulus(1'b1, 1'b1);
        wait_frame("s4", 3000);
        step(20);
        check_stream("s4");
        check_output("s4_done_count", done_count, 1);
        check_output("s4_idle_after", busy, 0);

        // Reset while page 1 data byte 40 is on the output.
        clear_monitor();
        apply_stimulus(1'b1, 1'b1);
        n = 0;
        while (!(byte_q.size() == PAGE_BYTES + 3 + 40 && sif.out_valid) && n < 2000) begin
            step(1);
            n++;
        end
        check_output("s5_reached_byte", int'(n < 2000), 1);
        check_output("s5_byte40_value", {23'd0, sif.out_dc, sif.out_data}, 9'h1A8);
        apply_stimulus(1'b0, 1'b0);
        check_output("s5_valid_after_rst", sif.out_valid, 0);
        check_output("s5_busy_after_rst", busy, 0);
        apply_stimulus(1'b0, 1'b1);
        step(10);
        check_output("s5_no_done", done_count, 0);
        clear_monitor();
        apply_stimulus(1'b1, 1'b1);
        check_output("s5_restart_valid", sif.out_valid, 1);
        check_output("s5_restart_data", sif.out_data, 8'hB0);
        check_output("s5_restart_dc", sif.out_dc, 0);
        wait_frame("s5", 3000);
        step(2);
        check_stream("s5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
